dtc_req_scheduler: RTL and testbench

//  Shares one combinational decision-tree classifier (FEAT_W-bit feature in,

---
 rtl/dtc_req_scheduler.sv | 114 +++++++++++
 tb/tb_dtc_req_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_req_scheduler.sv
// Round-robin scheduler sharing one external combinational decision-tree classifier
// between N_REQ requesters. Optional per-class result counters under DTC_STATS_EN.
module dtc_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int FEAT_W  = 11,
    parameter int CLASS_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*FEAT_W-1:0]     req_feat,
    output logic [FEAT_W-1:0]           cls_inp,
    input  logic [CLASS_W-1:0]          cls_outp,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [CLASS_W-1:0]          res_class,
    output logic [$clog2(N_REQ)-1:0]    res_id,
    output logic                        busy
`ifdef DTC_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [(2**CLASS_W)*CNT_W-1:0] class_cnt
`endif
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            window;
    logic            hs;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    assign window    = rst_n && ((state == IDLE) || (state == RESP && res_valid && res_ready));
    assign hs        = window && found;
    assign req_ready = hs ? (N_REQ'(1) << grant_id) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(N_REQ - 1);
            id_q      <= '0;
            cls_inp   <= '0;
            res_valid <= 1'b0;
            res_class <= '0;
            res_id    <= '0;
        end else begin
            // Capture is shared by IDLE and the RESP back-to-back path; hs is only true there.
            if (hs) begin
                cls_inp <= req_feat[grant_id*FEAT_W +: FEAT_W];
                id_q    <= grant_id;
                rr_ptr  <= grant_id;
            end
            case (state)
                IDLE: begin
                    if (hs) state <= EVAL;
                end
                EVAL: begin
                    res_class <= cls_outp;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= hs ? EVAL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DTC_STATS_EN
    logic [CNT_W-1:0] cnt_q [2**CLASS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 2**CLASS_W; k++) cnt_q[k] <= '0;
        end else if (stats_clr) begin
            for (int unsigned k = 0; k < 2**CLASS_W; k++) cnt_q[k] <= '0;
        end else if (res_valid && res_ready && (cnt_q[res_class] != '1)) begin
            cnt_q[res_class] <= cnt_q[res_class] + 1'b1;
        end
    end

    for (genvar gk = 0; gk < 2**CLASS_W; gk++) begin : g_cnt
        assign class_cnt[gk*CNT_W +: CNT_W] = cnt_q[gk];
    end
`endif

endmodule

// File: tb/tb_dtc_req_scheduler.sv
// Bench for dtc_req_scheduler: occupancy-based reference model checked every cycle,
// directed reset/single/round-robin/backpressure/reset-in-flight cases, then random traffic.
module tb_dtc_req_scheduler;
    localparam int N  = 4;
    localparam int FW = 11;
    localparam int CW = 3;
`ifdef DTC_STATS_EN
    localparam int CNTW = 2;
`else
    localparam int CNTW = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*FW-1:0]   req_feat;
    logic [FW-1:0]     cls_inp;
    logic [CW-1:0]     cls_outp;
    logic              res_valid;
    logic              res_ready;
    logic [CW-1:0]     res_class;
    logic [1:0]        res_id;
    logic              busy;
`ifdef DTC_STATS_EN
    logic                       stats_clr;
    logic [(2**CW)*CNTW-1:0]    class_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dtc_req_scheduler #(.N_REQ(N), .FEAT_W(FW), .CLASS_W(CW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_feat(req_feat), .cls_inp(cls_inp), .cls_outp(cls_outp),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_id(res_id), .busy(busy)
`ifdef DTC_STATS_EN
        , .stats_clr(stats_clr), .class_cnt(class_cnt)
`endif
    );

    // Classifier stub: 11'h008 -> 3'b101.
    function automatic logic [CW-1:0] stub(input logic [FW-1:0] f);
        return f[2:0] ^ f[5:3] ^ 3'b100;
    endfunction
    assign cls_outp = stub(cls_inp);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks "a feature is in the classifier" and "a result is outstanding".
    int          m_rr;
    bit          m_infl;
    int          m_id;
    logic [FW-1:0] m_cls_inp;
    bit          m_res;
    logic [CW-1:0] m_class;
    int          m_rid;
    int          m_cnt [2**CW];

    always @(negedge clk) begin : model
        int g;
        bit win;
        bit had_infl;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            m_rr = N - 1; m_infl = 0; m_id = 0; m_cls_inp = '0;
            m_res = 0; m_class = '0; m_rid = 0;
            for (int k = 0; k < 2**CW; k++) m_cnt[k] = 0;
        end
        g = -1;
        win = rst_n && !m_infl && (!m_res || res_ready);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (g < 0 && req_valid[i]) g = i;
        end
        exp_ready = (win && g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(m_infl || m_res));
        chk("res_valid", 64'(res_valid), 64'(m_res));
        chk("cls_inp", 64'(cls_inp), 64'(m_cls_inp));
        if (m_res || !rst_n) begin
            chk("res_class", 64'(res_class), 64'(m_class));
            chk("res_id", 64'(res_id), 64'(m_rid));
        end
`ifdef DTC_STATS_EN
        for (int k = 0; k < 2**CW; k++)
            chk("class_cnt", 64'(class_cnt[k*CNTW +: CNTW]), 64'(m_cnt[k]));
`endif
        if (rst_n) begin
            had_infl = m_infl;
`ifdef DTC_STATS_EN
            if (stats_clr) begin
                for (int k = 0; k < 2**CW; k++) m_cnt[k] = 0;
            end else if (m_res && res_ready && m_cnt[m_class] < 2**CNTW - 1) begin
                m_cnt[m_class]++;
            end
`endif
            if (m_res && res_ready) m_res = 0;
            if (had_infl) begin
                m_res = 1; m_class = stub(m_cls_inp); m_rid = m_id;
            end
            if (win && g >= 0) begin
                m_infl = 1; m_id = g; m_cls_inp = req_feat[g*FW +: FW]; m_rr = g;
            end else begin
                m_infl = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '1;
        req_feat = {$urandom, $urandom};
        res_ready = 1'b0;
`ifdef DTC_STATS_EN
        stats_clr = 1'b0;
`endif
        // T1 reset
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'h0);
        chk("t1_res_valid", 64'(res_valid), 64'h0);
        chk("t1_cls_inp", 64'(cls_inp), 64'h0);
        chk("t1_busy", 64'(busy), 64'h0);

        // T2 single request from requester 2
        step();
        rst_n = 1'b1;
        req_valid = 4'b0100;
        req_feat[2*FW +: FW] = 11'h008;
        @(negedge clk);
        chk("t2_req_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t2_eval_valid", 64'(res_valid), 64'h0);
        step();
        @(negedge clk);
        chk("t2_res_valid", 64'(res_valid), 64'h1);
        chk("t2_res_class", 64'(res_class), 64'h5);
        chk("t2_res_id", 64'(res_id), 64'h2);

        // T3 round-robin with all requesters active
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_grant", 64'(req_ready), (c % 2 == 0) ? (64'h1 << ((c / 2) % N)) : 64'h0);
            step();
        end

        // T4 backpressure in RESP
        res_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("t4_res_valid", 64'(res_valid), 64'h1);
            chk("t4_res_id", 64'(res_id), 64'h0);
            chk("t4_req_ready", 64'(req_ready), 64'h0);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_next_grant", 64'(req_ready), 64'h2);
        step();

        // T5 async reset while evaluating
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_res_valid", 64'(res_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        step();
        rst_n = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("t5_grant", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (res_valid) break;
            step();
        end
        chk("t5_done_valid", 64'(res_valid), 64'h1);
        chk("t5_done_id", 64'(res_id), 64'h1);
        step();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom % 600) != 0;
            req_valid = N'($urandom);
            req_feat = {$urandom, $urandom};
            res_ready = ($urandom % 4) != 0;
`ifdef DTC_STATS_EN
            stats_clr = ($urandom % 50) == 0;
`endif
            step();
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
